// File: rtl/regfile_sequencer_pkg.sv
// regfile_pkg -- shared encodings for the register-file sequencer.
//   op_t    : command opcodes carried on CmdOp
//   fs_t    : register-file function selects driven on FunSel
//   state_t : sequencer FSM states
// Build option: REGSEQ_SWAP_EN adds the SWAP states and the degenerate-SWAP
// helper; without it opcode 110 is executed as a NOP.
package regfile_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_CLR  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_LDI  = 3'b100,
        OP_MOV  = 3'b101,
        OP_SWAP = 3'b110,
        OP_INCN = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        FS_DEC  = 3'b000,
        FS_INC  = 3'b001,
        FS_LOAD = 3'b010,
        FS_CLR  = 3'b011
    } fs_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_REPT = 3'd2
`ifdef REGSEQ_SWAP_EN
        ,
        ST_SWP1 = 3'd3,
        ST_SWP2 = 3'd4,
        ST_SWP3 = 3'd5
`endif
    } state_t;

`ifdef REGSEQ_SWAP_EN
    // A swap through the temporary is meaningless (or destructive) when the
    // operands coincide or one of them is the temporary itself.
    function automatic logic swap_degenerate(input logic [2:0] dst,
                                             input logic [2:0] src,
                                             input logic [2:0] tmp);
        return (dst == src) || (dst == tmp) || (src == tmp);
    endfunction
`endif

endpackage

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if -- command handshake plus register-file control bus.
//   Command side : CmdValid/CmdReady handshake, CmdOp, CmdDst, CmdSrc,
//                  CmdImm, CmdCount
//   Control side : FunSel, RegSel/ScrSel (active-low enables), OutASel,
//                  OutBSel, ImmOut, ISel, Busy, Done
//   master : command issuer / register-file consumer
//   slave  : the sequencer
interface regfile_sequencer_if;
    logic        CmdValid;
    logic        CmdReady;
    logic [2:0]  CmdOp;
    logic [2:0]  CmdDst;
    logic [2:0]  CmdSrc;
    logic [15:0] CmdImm;
    logic [3:0]  CmdCount;
    logic [2:0]  FunSel;
    logic [3:0]  RegSel;
    logic [3:0]  ScrSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] ImmOut;
    logic        ISel;
    logic        Busy;
    logic        Done;

    modport master (
        output CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, CmdCount,
        input  CmdReady, FunSel, RegSel, ScrSel, OutASel, OutBSel,
               ImmOut, ISel, Busy, Done
    );

    modport slave (
        input  CmdValid, CmdOp, CmdDst, CmdSrc, CmdImm, CmdCount,
        output CmdReady, FunSel, RegSel, ScrSel, OutASel, OutBSel,
               ImmOut, ISel, Busy, Done
    );
endinterface

// File: rtl/regfile_sequencer_regsel_decode.sv
// regsel_decode -- 3-bit register index to active-low write enables.
//   idx    : 0-3 = R1-R4, 4-7 = S1-S4
//   en     : write this cycle
//   regsel : R enables, bit3 = R1 .. bit0 = R4 (active low)
//   scrsel : S enables, bit3 = S1 .. bit0 = S4 (active low)
module regsel_decode (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [3:0] regsel,
    output logic [3:0] scrsel
);
    logic [3:0] hot;

    always_comb begin
        hot    = 4'b1000 >> idx[1:0];
        regsel = '1;
        scrsel = '1;
        if (en) begin
            if (idx[2]) scrsel = ~hot;
            else        regsel = ~hot;
        end
    end
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer -- turns register-file commands into per-cycle control.
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : regfile_sequencer_if.slave (command handshake + control outputs)
//   TMP_REG : register index used as the SWAP temporary
// Build option: define REGSEQ_SWAP_EN for the three-cycle SWAP; otherwise
// opcode 110 completes as a one-cycle NOP.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter logic [2:0] TMP_REG = 3'd7
) (
    input  logic                  Clock,
    input  logic                  Reset,
    regfile_sequencer_if.slave    bus
);
    state_t      state, state_nx;
    op_t         op_q;
    logic [2:0]  dst_q, src_q;
    logic [15:0] imm_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic        idle;
    fs_t         fs;
    logic        isel;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [2:0]  outa;
    logic        done;
    logic [3:0]  regsel, scrsel;

    assign idle   = (state == ST_IDLE);
    assign accept = idle && bus.CmdValid;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
            dst_q <= '0;
            src_q <= '0;
            imm_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op_t'(bus.CmdOp);
                dst_q <= bus.CmdDst;
                src_q <= bus.CmdSrc;
                imm_q <= bus.CmdImm;
                cnt_q <= bus.CmdCount;
            end else if (state == ST_REPT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        fs       = FS_DEC;
        isel     = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = dst_q;
        outa     = '0;
        done     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.CmdValid) begin
                    case (op_t'(bus.CmdOp))
`ifdef REGSEQ_SWAP_EN
                        OP_SWAP: state_nx = swap_degenerate(bus.CmdDst, bus.CmdSrc, TMP_REG)
                                            ? ST_EXEC : ST_SWP1;
`endif
                        OP_INCN: state_nx = (bus.CmdCount != '0) ? ST_REPT : ST_EXEC;
                        default: state_nx = ST_EXEC;
                    endcase
                end
            end

            // NOP, zero-count INCN and degenerate/disabled SWAP land here
            // with no write enable and still complete with Done.
            ST_EXEC: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
                case (op_q)
                    OP_CLR: begin fs = FS_CLR;  wr_en = 1'b1; end
                    OP_INC: begin fs = FS_INC;  wr_en = 1'b1; end
                    OP_DEC: begin fs = FS_DEC;  wr_en = 1'b1; end
                    OP_LDI: begin fs = FS_LOAD; wr_en = 1'b1; end
                    OP_MOV: begin fs = FS_LOAD; wr_en = 1'b1; isel = 1'b1; outa = src_q; end
                    default: ;
                endcase
            end

            ST_REPT: begin
                fs    = FS_INC;
                wr_en = 1'b1;
                if (cnt_q == 4'd1) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end

`ifdef REGSEQ_SWAP_EN
            ST_SWP1: begin
                fs = FS_LOAD; isel = 1'b1; wr_en = 1'b1;
                outa = src_q; wr_idx = TMP_REG;
                state_nx = ST_SWP2;
            end
            ST_SWP2: begin
                fs = FS_LOAD; isel = 1'b1; wr_en = 1'b1;
                outa = dst_q; wr_idx = src_q;
                state_nx = ST_SWP3;
            end
            ST_SWP3: begin
                fs = FS_LOAD; isel = 1'b1; wr_en = 1'b1;
                outa = TMP_REG; wr_idx = dst_q;
                done = 1'b1;
                state_nx = ST_IDLE;
            end
`endif

            default: state_nx = ST_IDLE;
        endcase
    end

    regsel_decode u_decode (
        .idx    (wr_idx),
        .en     (wr_en),
        .regsel (regsel),
        .scrsel (scrsel)
    );

    assign bus.CmdReady = idle;
    assign bus.Busy     = !idle;
    assign bus.Done     = done;
    assign bus.FunSel   = fs;
    assign bus.ISel     = isel;
    assign bus.RegSel   = regsel;
    assign bus.ScrSel   = scrsel;
    assign bus.OutASel  = outa;
    assign bus.OutBSel  = idle ? 3'b000 : dst_q;
    assign bus.ImmOut   = imm_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer -- scoreboard bench for regfile_sequencer.
// Expected per-cycle control vectors are queued when a command is issued and
// compared one per falling edge. Expectations follow REGSEQ_SWAP_EN.
module tb_regfile_sequencer;
    import regfile_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    regfile_sequencer_if bus();

    regfile_sequencer #(.TMP_REG(3'd7)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    localparam logic [3:0] OFF = 4'b1111;

    // {CmdReady, Busy, Done, FunSel, ISel, RegSel, ScrSel, OutASel, OutBSel}
    function automatic logic [20:0] mk(input logic rdy, input logic dn,
                                       input logic [2:0] fsel, input logic is,
                                       input logic [3:0] rs, input logic [3:0] ss,
                                       input logic [2:0] oa, input logic [2:0] ob);
        return {rdy, ~rdy, dn, fsel, is, rs, ss, oa, ob};
    endfunction

    function automatic logic [20:0] idle_v();
        return mk(1'b1, 1'b0, 3'b000, 1'b0, OFF, OFF, 3'd0, 3'd0);
    endfunction

    function automatic logic [20:0] nop_v(input logic [2:0] dst);
        return mk(1'b0, 1'b1, 3'b000, 1'b0, OFF, OFF, 3'd0, dst);
    endfunction

    function automatic logic [20:0] obs();
        return {bus.CmdReady, bus.Busy, bus.Done, bus.FunSel, bus.ISel,
                bus.RegSel, bus.ScrSel, bus.OutASel, bus.OutBSel};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic expect_cycle(input string tag, input logic [20:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge Clock);
            check(tag_q.pop_front(), {11'd0, obs()}, {11'd0, exp_q.pop_front()});
        end
    endtask

    // Called at a falling edge while idle; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                        input logic [15:0] imm, input logic [3:0] cnt);
        bus.CmdOp    = op;
        bus.CmdDst   = dst;
        bus.CmdSrc   = src;
        bus.CmdImm   = imm;
        bus.CmdCount = cnt;
        bus.CmdValid = 1'b1;
        check("accept_ready", {31'd0, bus.CmdReady}, 32'd1);
        @(posedge Clock);
        #1 bus.CmdValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [2:0] mov_dst [3] = '{3'd1, 3'd2, 3'd5};
    logic [2:0] mov_src [3] = '{3'd6, 3'd4, 3'd3};
    logic [3:0] mov_rs  [3] = '{4'b1011, 4'b1101, 4'b1111};
    logic [3:0] mov_ss  [3] = '{4'b1111, 4'b1111, 4'b1011};

    initial begin
        bus.CmdValid = 1'b0;
        bus.CmdOp    = '0;
        bus.CmdDst   = '0;
        bus.CmdSrc   = '0;
        bus.CmdImm   = '0;
        bus.CmdCount = '0;

        #2;
        check("reset_outputs", {11'd0, obs()}, {11'd0, idle_v()});
        check("reset_imm", {16'd0, bus.ImmOut}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // LDI R3 <- BEEF
        expect_cycle("ldi_exec", mk(1'b0, 1'b1, 3'b010, 1'b0, 4'b1101, OFF, 3'd0, 3'd2));
        expect_cycle("ldi_idle", idle_v());
        send(OP_LDI, 3'd2, 3'd0, 16'hBEEF, 4'd0);
        drain();
        check("ldi_immout", {16'd0, bus.ImmOut}, 32'h0000BEEF);

        // CLR S4, INC R1, DEC S2
        expect_cycle("clr_exec", mk(1'b0, 1'b1, 3'b011, 1'b0, OFF, 4'b1110, 3'd0, 3'd7));
        expect_cycle("clr_idle", idle_v());
        send(OP_CLR, 3'd7, 3'd0, 16'h0, 4'd0);
        drain();
        expect_cycle("inc_exec", mk(1'b0, 1'b1, 3'b001, 1'b0, 4'b0111, OFF, 3'd0, 3'd0));
        expect_cycle("inc_idle", idle_v());
        send(OP_INC, 3'd0, 3'd0, 16'h0, 4'd0);
        drain();
        expect_cycle("dec_exec", mk(1'b0, 1'b1, 3'b000, 1'b0, OFF, 4'b1011, 3'd0, 3'd5));
        expect_cycle("dec_idle", idle_v());
        send(OP_DEC, 3'd5, 3'd0, 16'h0, 4'd0);
        drain();

        // SWAP R1 <-> S2 through S4
`ifdef REGSEQ_SWAP_EN
        expect_cycle("swap_c1", mk(1'b0, 1'b0, 3'b010, 1'b1, OFF, 4'b1110, 3'd5, 3'd0));
        expect_cycle("swap_c2", mk(1'b0, 1'b0, 3'b010, 1'b1, OFF, 4'b1011, 3'd0, 3'd0));
        expect_cycle("swap_c3", mk(1'b0, 1'b1, 3'b010, 1'b1, 4'b0111, OFF, 3'd7, 3'd0));
`else
        expect_cycle("swap_off_nop", nop_v(3'd0));
`endif
        expect_cycle("swap_idle", idle_v());
        send(OP_SWAP, 3'd0, 3'd5, 16'h0, 4'd0);
        drain();

        // INCN S1 x3
        expect_cycle("incn_c1", mk(1'b0, 1'b0, 3'b001, 1'b0, OFF, 4'b0111, 3'd0, 3'd4));
        expect_cycle("incn_c2", mk(1'b0, 1'b0, 3'b001, 1'b0, OFF, 4'b0111, 3'd0, 3'd4));
        expect_cycle("incn_c3", mk(1'b0, 1'b1, 3'b001, 1'b0, OFF, 4'b0111, 3'd0, 3'd4));
        expect_cycle("incn_idle", idle_v());
        send(OP_INCN, 3'd4, 3'd0, 16'h0, 4'd3);
        drain();

        // Degenerate commands: one cycle, no enables, Done
        expect_cycle("incn0_nop", nop_v(3'd1));
        expect_cycle("incn0_idle", idle_v());
        send(OP_INCN, 3'd1, 3'd0, 16'h0, 4'd0);
        drain();
        expect_cycle("swap_same_nop", nop_v(3'd3));
        expect_cycle("swap_same_idle", idle_v());
        send(OP_SWAP, 3'd3, 3'd3, 16'h0, 4'd0);
        drain();
        expect_cycle("swap_tmp_nop", nop_v(3'd7));
        expect_cycle("swap_tmp_idle", idle_v());
        send(OP_SWAP, 3'd7, 3'd2, 16'h0, 4'd0);
        drain();
        expect_cycle("nop_exec", nop_v(3'd6));
        expect_cycle("nop_idle", idle_v());
        send(OP_NOP, 3'd6, 3'd1, 16'h0, 4'd0);
        drain();

        // Back-to-back MOV with CmdValid held: one acceptance per two cycles
        bus.CmdOp    = OP_MOV;
        bus.CmdValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.CmdDst = mov_dst[i];
            bus.CmdSrc = mov_src[i];
            expect_cycle("mov_exec", mk(1'b0, 1'b1, 3'b010, 1'b1, mov_rs[i], mov_ss[i],
                                        mov_src[i], mov_dst[i]));
            if (i < 2) expect_cycle("mov_idle", idle_v());
            drain();
        end
        bus.CmdValid = 1'b0;
        expect_cycle("mov_last_idle", idle_v());
        drain();

        // Reset in the middle of INCN
        expect_cycle("incn_rst_c1", mk(1'b0, 1'b0, 3'b001, 1'b0, OFF, 4'b1101, 3'd0, 3'd6));
        expect_cycle("incn_rst_c2", mk(1'b0, 1'b0, 3'b001, 1'b0, OFF, 4'b1101, 3'd0, 3'd6));
        send(OP_INCN, 3'd6, 3'd0, 16'h0, 4'd5);
        drain();
        #1 Reset = 1'b0;
        #1 check("incn_rst_async", {11'd0, obs()}, {11'd0, idle_v()});
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) expect_cycle("incn_rst_after", idle_v());
        drain();

`ifdef REGSEQ_SWAP_EN
        // Reset during SWP2: nothing written afterwards, temporary included
        expect_cycle("swrst_c1", mk(1'b0, 1'b0, 3'b010, 1'b1, OFF, 4'b1110, 3'd4, 3'd1));
        expect_cycle("swrst_c2", mk(1'b0, 1'b0, 3'b010, 1'b1, OFF, 4'b0111, 3'd1, 3'd1));
        send(OP_SWAP, 3'd1, 3'd4, 16'h0, 4'd0);
        drain();
        #1 Reset = 1'b0;
        #1 check("swap_rst_async", {11'd0, obs()}, {11'd0, idle_v()});
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) expect_cycle("swap_rst_after", idle_v());
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have parameter TMP_REG, default 3'd7, meaning register index (S4) used as the SWAP temporary.
REQ-002 SHALL have port Clock  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port CmdValid  input  1  command present.
REQ-005 SHALL have port CmdReady  output  1  sequencer accepts a command this cycle.
REQ-006 SHALL have port CmdOp  input  3  000 NOP, 001 CLR, 010 INC, 011 DEC, 100 LDI, 101 MOV, 110 SWAP, 111 INCN.
REQ-007 SHALL have ports CmdDst, CmdSrc  input  3 each  register index: 0-3 = R1-R4, 4-7 = S1-S4.
REQ-008 SHALL have ports CmdImm  input  16  LDI data; CmdCount  input  4  INCN repeat count.
REQ-009 SHALL have ports FunSel  output  3, and RegSel, ScrSel  output  4 each (active-low enables; bit3 = R1/S1, bit0 = R4/S4).
REQ-010 SHALL have ports OutASel, OutBSel  output  3 each  register-file read selects.
REQ-011 SHALL have ports ImmOut  output  16  latched immediate; ISel  output  1  register-file input source (0 = ImmOut, 1 = OutA feedback).
REQ-012 SHALL have ports Busy  output  1  command in progress; Done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL accept a command on a rising edge where CmdValid && CmdReady and SHALL latch Op, Dst, Src, Imm and Count.
REQ-014 SHALL drive CmdReady = 1 only in IDLE; Busy SHALL equal !CmdReady.
REQ-015 SHALL use states IDLE, EXEC, SWP1, SWP2, SWP3 and REPT.
REQ-016 SHALL, for an accepted command, move from IDLE to SWP1 for SWAP, to REPT for INCN with Count != 0, and to EXEC for all other commands.
REQ-017 SHALL, in EXEC, assert exactly one active-low enable (Dst), assert Done, and return to IDLE.
REQ-018 SHALL, in EXEC, drive FunSel as follows: CLR 011, INC 001, DEC 000, LDI 010 with ISel = 0, MOV 010 with ISel = 1 and OutASel = Src.
REQ-019 SHALL, for NOP or INCN with Count = 0, spend one EXEC cycle with all enables high and assert Done.
REQ-020 SHALL execute SWAP over three cycles, each with FunSel = 010 and ISel = 1: SWP1 OutASel = Src, enable TMP_REG; SWP2 OutASel = Dst, enable Src; SWP3 OutASel = TMP_REG, enable Dst, assert Done.
REQ-021 SHALL treat a SWAP with Dst == Src, or with either operand == TMP_REG, as NOP.
REQ-022 SHALL execute INCN in REPT by enabling Dst with FunSel = 001 for exactly Count cycles, decrementing an internal 4-bit counter, and asserting Done on the last cycle.
REQ-023 SHALL drive OutBSel = latched Dst whenever Busy, and 0 otherwise.
REQ-024 SHALL, outside any write cycle, hold RegSel = ScrSel = 4'b1111, FunSel = 000 and ISel = 0.
REQ-025 SHALL ignore CmdValid while Busy; a command held valid SHALL be accepted on the first IDLE edge.
REQ-026 SHALL give single-cycle commands a latency of one write cycle after acceptance and a throughput of one command per 2 cycles.

Reset
REQ-027 SHALL, on Reset low, immediately force IDLE, CmdReady = 1, Busy = 0, Done = 0, RegSel = ScrSel = 4'b1111, FunSel = 000, OutASel = OutBSel = 000, ISel = 0 and ImmOut = 0.
REQ-028 SHALL, if reset arrives mid-SWAP or mid-INCN, abort with no further enables after reset asserts.

Configuration
REQ-029 SHALL, with REGSEQ_SWAP_EN defined, implement SWAP as in REQ-020/021.
REQ-030 SHALL, without REGSEQ_SWAP_EN, decode op 110 as NOP (one EXEC cycle, no enables, Done) and omit the SWP states.

Structure
REQ-031 SHALL place the opcode, FunSel (FS_DEC 000, FS_INC 001, FS_LOAD 010, FS_CLR 011) and state encodings in shared package regfile_pkg.
REQ-032 SHALL implement the 3-bit index to RegSel/ScrSel active-low decode as sub-module regsel_decode.

Verification
REQ-033 SHALL verify: LDI Dst = 2, Imm = 16'hBEEF -> next cycle RegSel = 4'b1101, FunSel = 010, ISel = 0, ImmOut = BEEF, Done = 1.
REQ-034 SHALL verify: SWAP Dst = 0, Src = 5 -> ScrSel = 1110, then ScrSel = 1011, then RegSel = 0111, with OutASel sequence 5, 0, 7; Done only in the third cycle.
REQ-035 SHALL verify: INCN Dst = 4, Count = 3 -> ScrSel = 0111 with FunSel = 001 for exactly 3 cycles; Done on the third; CmdReady = 0 throughout.
REQ-036 SHALL verify: INCN with Count = 0, and SWAP with Dst = Src = 3 -> one cycle, all enables 1111, Done = 1.
REQ-037 SHALL verify: Reset low during SWP2 -> all enables 1111 immediately, CmdReady = 1 after release, TMP_REG is not written again.
REQ-038 SHALL verify: back-to-back MOV commands with CmdValid held -> acceptance every 2 cycles, no enable asserted while in IDLE.
